// File: rtl/mips_defs_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch FSM states and PC increment.
package mips_defs_pkg;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] J     = 6'h02;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] ADDIU = 6'h09;
  localparam logic [5:0] SLTI  = 6'h0A;
  localparam logic [5:0] SLTIU = 6'h0B;
  localparam logic [5:0] ANDI  = 6'h0C;
  localparam logic [5:0] ORI   = 6'h0D;
  localparam logic [5:0] XORI  = 6'h0E;
  localparam logic [5:0] LUI   = 6'h0F;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory and core-side handshakes of the fetch unit.
interface instruction_fetch_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 IMemReq;
  logic [31:0]          IMemAddr;
  logic                 IMemReady;
  logic [31:0]          IMemData;
  logic                 InstrValid;
  logic [31:0]          Instruction;
  logic [5:0]           Opcode;
  logic [31:0]          PC;
  logic                 InstrAck;
  logic                 Branch;
  logic                 Jump;
  logic                 Zero;
  logic [CNT_WIDTH-1:0] RetiredCount;

  modport master (
    output IMemReq, IMemAddr, InstrValid, Instruction, Opcode, PC, RetiredCount,
    input  IMemReady, IMemData, InstrAck, Branch, Jump, Zero
  );

  modport slave (
    input  IMemReq, IMemAddr, InstrValid, Instruction, Opcode, PC, RetiredCount,
    output IMemReady, IMemData, InstrAck, Branch, Jump, Zero
  );
endinterface

// File: rtl/instruction_fetch_unit_next_pc.sv
// Combinational next-PC selection: jump, taken branch, or sequential PC+4.
module next_pc_calc
  import mips_defs_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] NextPC
);

  logic        [31:0] pc_plus4;
  logic signed [31:0] br_off;
  logic        [31:0] jmp_tgt;

  assign pc_plus4 = PC + PC_INCR;
  assign br_off   = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], Instruction[25:0], 2'b00};

  // Jump outranks branch when the decoder asserts both.
  always_comb begin
    NextPC = pc_plus4;
    if (Jump) begin
      NextPC = jmp_tgt;
    end else if (Branch && Zero) begin
      NextPC = pc_plus4 + $unsigned(br_off);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS front end: owns the PC, fetches over req/ready and issues over valid/ack.
module instruction_fetch_unit
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_t         state_q;
  logic [31:0]          pc_q;
  logic                 req_q;
  logic                 vld_q;
  logic [31:0]          instr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [31:0]          next_pc_d;

  next_pc_calc u_next_pc (
    .PC          (pc_q),
    .Instruction (instr_q),
    .Branch      (bus.Branch),
    .Jump        (bus.Jump),
    .Zero        (bus.Zero),
    .NextPC      (next_pc_d)
  );

  // Branch/Jump/Zero only reach state through the ISSUE ack path.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC_ALIGNED;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          req_q   <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.IMemReady) begin
            instr_q <= bus.IMemData;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.InstrAck) begin
            pc_q    <= next_pc_d;
            vld_q   <= 1'b0;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign bus.IMemReq      = req_q;
  assign bus.IMemAddr     = pc_q;
  assign bus.InstrValid   = vld_q;
  assign bus.Instruction  = instr_q;
  assign bus.Opcode       = instr_q[31:26];
  assign bus.PC           = pc_q;
  assign bus.RetiredCount = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, reset corner cases, random traffic.
module tb_instruction_fetch_unit;
  import mips_defs_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  instruction_fetch_unit_if #(.CNT_WIDTH(32)) bus();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0403),
    .CNT_WIDTH (32)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  typedef struct {
    logic [31:0] ins;
    logic        br;
    logic        jp;
    logic        zr;
    int          mdly;
    logic [31:0] exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.IMemReady = 1'b0;
    bus.IMemData  = '0;
    bus.InstrAck  = 1'b0;
    bus.Branch    = 1'b0;
    bus.Jump      = 1'b0;
    bus.Zero      = 1'b0;
  endtask

  // Architectural next-PC rule evaluated with wide integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic br, input logic jp, input logic zr);
    longint m;
    longint p4;
    longint off;
    m  = longint'(1) << 32;
    p4 = (longint'(pc) + 4) % m;
    if (jp) return 32'((p4 / 268435456) * 268435456 + (longint'(ins) % 67108864) * 4);
    if (br && zr) begin
      off = longint'(ins[15:0]);
      if (off >= 32768) off = off - 65536;
      return 32'((p4 + off * 4 + m) % m);
    end
    return 32'(p4);
  endfunction

  // Entered in a FETCH cycle; leaves in the FETCH cycle after the ack edge.
  task automatic run_instr(input logic [31:0] ins, input logic br, input logic jp, input logic zr,
                           input int mdly, input int adly, input bit noise);
    chk("fetch_req_low", bus.IMemReq, 0);
    chk("fetch_valid_low", bus.InstrValid, 0);
    chk("fetch_pc", bus.PC, m_pc);
    if (noise) begin
      bus.InstrAck  = 1'b1;
      bus.IMemReady = 1'b1;
      bus.Jump      = 1'($urandom);
      bus.Branch    = 1'($urandom);
    end
    tick();
    for (int i = 0; i < mdly; i++) begin
      bus.IMemReady = 1'b0;
      bus.IMemData  = $urandom;
      bus.InstrAck  = noise ? 1'($urandom) : 1'b0;
      chk("wait_req", bus.IMemReq, 1);
      chk("wait_addr", bus.IMemAddr, m_pc);
      chk("wait_valid_low", bus.InstrValid, 0);
      tick();
    end
    chk("wait_req", bus.IMemReq, 1);
    chk("wait_addr", bus.IMemAddr, m_pc);
    chk("wait_valid_low", bus.InstrValid, 0);
    bus.IMemReady = 1'b1;
    bus.IMemData  = ins;
    bus.InstrAck  = 1'b0;
    tick();
    bus.IMemReady = noise ? 1'($urandom) : 1'b0;
    bus.IMemData  = $urandom;
    chk("issue_valid", bus.InstrValid, 1);
    chk("issue_req_low", bus.IMemReq, 0);
    chk("issue_instr", bus.Instruction, ins);
    chk("issue_opcode", bus.Opcode, ins[31:26]);
    chk("issue_pc", bus.PC, m_pc);
    chk("issue_cnt", bus.RetiredCount, m_cnt);
    for (int i = 0; i < adly; i++) begin
      bus.InstrAck = 1'b0;
      bus.Branch   = 1'bx;
      bus.Jump     = 1'bx;
      tick();
      chk("hold_valid", bus.InstrValid, 1);
      chk("hold_instr", bus.Instruction, ins);
      chk("hold_pc", bus.PC, m_pc);
    end
    bus.InstrAck = 1'b1;
    bus.Branch   = br;
    bus.Jump     = jp;
    bus.Zero     = zr;
    tick();
    m_pc  = ref_next(m_pc, ins, br, jp, zr);
    m_cnt = m_cnt + 1;
    drive_idle();
    chk("ack_valid_low", bus.InstrValid, 0);
    chk("ack_next_pc", bus.PC, m_pc);
    chk("ack_cnt", bus.RetiredCount, m_cnt);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{32'h0800_0000, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0004};
    vecs[2]  = '{32'h2001_0005, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0008};
    vecs[3]  = '{32'h8C22_0004, 1'b0, 1'b0, 1'b0, 0, 32'h0000_000C};
    vecs[4]  = '{32'hAC22_0008, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0010};
    vecs[5]  = '{32'h3423_00FF, 1'b0, 1'b0, 1'b0, 5, 32'h0000_0014};
    vecs[6]  = '{32'h0800_0008, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0020};
    vecs[7]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0, 32'h0000_001C};
    vecs[8]  = '{32'h0800_0008, 1'b0, 1'b1, 1'b0, 1, 32'h0000_0020};
    vecs[9]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0024};
    vecs[10] = '{32'h0800_0000, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0000};
    vecs[11] = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 2, 32'hFFFF_FFFC};
    vecs[12] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0000};
    vecs[13] = '{32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0, 32'h0FFF_FFFC};
    vecs[14] = '{32'h0000_0020, 1'b1, 1'b0, 1'b0, 0, 32'h1000_0000};
    vecs[15] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 32'h1000_0100};

    drive_idle();
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_pc", bus.PC, 32'h0000_0400);
    chk("rst_addr", bus.IMemAddr, 32'h0000_0400);
    chk("rst_req", bus.IMemReq, 0);
    chk("rst_valid", bus.InstrValid, 0);
    chk("rst_instr", bus.Instruction, 0);
    chk("rst_opcode", bus.Opcode, 0);
    chk("rst_cnt", bus.RetiredCount, 0);
    Reset = 1'b0;
    m_pc  = 32'h0000_0400;
    m_cnt = 0;

    for (int v = 0; v < 16; v++) begin
      run_instr(vecs[v].ins, vecs[v].br, vecs[v].jp, vecs[v].zr, vecs[v].mdly, 0, 1'b0);
      chk($sformatf("vec%0d_pc", v), bus.PC, vecs[v].exp_pc);
    end
    chk("vec_cnt", bus.RetiredCount, 16);

    for (int r = 0; r < 40; r++) begin
      run_instr($urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
    end

    // Reset while WAIT sees a concurrent IMemReady.
    tick();
    chk("rw_req", bus.IMemReq, 1);
    bus.IMemReady = 1'b1;
    bus.IMemData  = 32'hDEAD_BEEF;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive_idle();
    chk("rw_req_low", bus.IMemReq, 0);
    chk("rw_valid_low", bus.InstrValid, 0);
    chk("rw_instr", bus.Instruction, 0);
    chk("rw_pc", bus.PC, 32'h0000_0400);
    chk("rw_cnt", bus.RetiredCount, 0);
    m_pc  = 32'h0000_0400;
    m_cnt = 0;
    run_instr(32'h2000_0001, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    // Reset while ISSUE coincides with an ack.
    tick();
    bus.IMemReady = 1'b1;
    bus.IMemData  = 32'h1000_0003;
    tick();
    chk("ri_valid", bus.InstrValid, 1);
    bus.IMemReady = 1'b0;
    bus.InstrAck  = 1'b1;
    bus.Branch    = 1'b1;
    bus.Zero      = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive_idle();
    chk("ri_valid_low", bus.InstrValid, 0);
    chk("ri_cnt", bus.RetiredCount, 0);
    chk("ri_pc", bus.PC, 32'h0000_0400);
    m_pc  = 32'h0000_0400;
    m_cnt = 0;
    run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the single-cycle MIPS core. It owns the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake. It presents Instruction and Opcode to the main control decoder with a valid/ack handshake. It consumes the decoder's Branch and Jump outputs plus the ALU Zero flag to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] forced to 0.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
CLK  in  1  system clock, rising-edge.
Reset  in  1  synchronous, active-high reset.
IMemReq  out  1  fetch request to instruction memory.
IMemAddr  out  32  fetch byte address; equals PC.
IMemReady  in  1  memory has IMemData valid this cycle (only meaningful while IMemReq=1).
IMemData  in  32  fetched instruction word.
InstrValid  out  1  Instruction/Opcode valid toward core.
Instruction  out  32  registered instruction word.
Opcode  out  6  Instruction[31:26], to control decoder.
PC  out  32  address of the current Instruction.
InstrAck  in  1  core finished the current instruction; Branch/Jump/Zero are valid this cycle.
Branch  in  1  from control decoder.
Jump  in  1  from control decoder.
Zero  in  1  ALU zero flag.
RetiredCount  out  CNT_WIDTH  count of acknowledged instructions.

Behaviour:
- Reset is synchronous and active-high. On the clock edge with Reset=1:
  - state=FETCH, PC={RESET_PC[31:2],2'b00}
  - IMemReq=0, InstrValid=0, Instruction=0, Opcode=0, RetiredCount=0.
- FSM states: FETCH, WAIT, ISSUE.
  - FETCH (one cycle, entered after reset or ack): register IMemReq=1 and IMemAddr=PC; go to WAIT.
  - WAIT: hold IMemReq=1 and IMemAddr stable until IMemReady=1. On that edge:
    - capture Instruction=IMemData and Opcode=IMemData[31:26];
    - IMemReq=0 and InstrValid=1 from the next cycle;
    - go to ISSUE.
    - No timeout; WAIT can last indefinitely.
  - ISSUE: hold InstrValid=1; Instruction, Opcode and PC stay stable until InstrAck=1. On the ack edge:
    - load PC with next PC;
    - InstrValid=0;
    - RetiredCount+1;
    - go to FETCH.
- Minimum cycle latency: ack edge → FETCH (1) → WAIT with IMemReady already high (1) → InstrValid high. Back-to-back instructions therefore take 3 cycles with zero-wait memory.
- Next-PC selection, in priority order:
  1. Jump=1: PC = {PCplus4[31:28], Instruction[25:0], 2'b00}.
  2. Branch=1 and Zero=1: PC = PCplus4 + (sign-extended Instruction[15:0] << 2).
  3. Otherwise: PC = PCplus4.
  - PCplus4 = PC + 4, computed in 32 bits.
- Arithmetic is modulo 2^32: PC 0xFFFF_FFFC + 4 wraps to 0x0000_0000. Branch targets wrap the same way.
- Jump=1 together with Branch=1: Jump wins.
- Branch, Jump and Zero are sampled only on the InstrAck edge while in ISSUE.
- Ignored inputs (no effect):
  - InstrAck while InstrValid=0.
  - IMemReady while IMemReq=0.
  - x/unknown Branch/Jump outside the ack cycle, e.g. decoder output for undefined opcodes.
- Reset mid-WAIT: the request is abandoned and IMemReq=0 in the cycle after the reset edge. A concurrent IMemReady is ignored.
- Reset during ISSUE: InstrValid drops and the pending ack is lost.
- RetiredCount wraps at 2^CNT_WIDTH.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package mips_defs_pkg:
  - opcode constants (RTYPE, LW, SW, BEQ, J, ORI, ADDI, ADDIU, ANDI, LUI, SLTI, SLTIU, XORI) shared with the control decoder;
  - FSM state enum fetch_state_t {FETCH, WAIT, ISSUE};
  - PC_INCR=4.
- One natural sub-module: next_pc_calc, purely combinational. Inputs PC, Instruction, Branch, Jump, Zero; output NextPC.

Test Plan:
- Reset with RESET_PC=32'h0000_0403 → PC=0x400, IMemAddr=0x400 in the first FETCH, InstrValid=0, RetiredCount=0.
- Sequential fetch, zero-wait memory, ack immediately each time → PCs 0x0,0x4,0x8, InstrValid rising every 3 cycles, RetiredCount=3.
- IMemReady delayed 5 cycles at PC=0x10 → IMemReq/IMemAddr held stable all 5 cycles, InstrValid stays 0 until the capture edge.
- BEQ at PC=0x20 with imm=16'hFFFE, Branch=1, Zero=1 → next PC=0x1C. Same instruction with Zero=0 → next PC=0x24.
- J at PC=0x1000_0000 with target=26'h000_0040, Jump=1 and Branch=1 together → next PC=0x1000_0100 (jump priority).
- Reset asserted in WAIT with IMemReady=1 the same cycle → Instruction not captured, IMemReq=0 next cycle, fetch restarts at RESET_PC. Separately, PC=0xFFFF_FFFC acked with no branch → next PC=0x0.
